// File: rtl/e_9_upcount_mod_async.sv
// Modulo-N up-counter 0..limit_i; wraps to 0 (default) or saturates at limit_i when E_9_SATURATE_EN is defined.
// Latency: count_o/wrap_o/sat_o registered, one clk_i edge after en/clr/load; tc_o combinational, zero latency.
// Backpressure: none; every enabled edge advances, priority clr > load > en > hold.
module e_9_upcount_mod_async #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             wrap_o,
    output logic             sat_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] load_clamped;
    logic             wrap_q, wrap_d;
    logic             at_or_above;

    // >= rather than == so a limit lowered under the count still terminates
    assign at_or_above  = (count_q >= limit_i);
    assign load_clamped = (load_val_i > limit_i) ? limit_i : load_val_i;

`ifdef E_9_SATURATE_EN
    logic sat_q, sat_d;
    logic armed_q, armed_d;

    // armed_q lets only the first saturation after clr/load/reset raise wrap
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        sat_d   = sat_q;
        armed_d = armed_q;
        if (clr_i) begin
            count_d = '0;
            sat_d   = 1'b0;
            armed_d = 1'b1;
        end else if (load_i) begin
            count_d = load_clamped;
            armed_d = 1'b1;
            if (load_clamped < limit_i) begin
                sat_d = 1'b0;
            end
        end else if (en_i) begin
            if (!at_or_above) begin
                count_d = count_q + 1'b1;
            end else begin
                count_d = limit_i;
                sat_d   = 1'b1;
                wrap_d  = armed_q;
                armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_q   <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            sat_q   <= sat_d;
            armed_q <= armed_d;
        end
    end

    assign sat_o = sat_q;
`else
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_clamped;
        end else if (en_i) begin
            if (!at_or_above) begin
                count_d = count_q + 1'b1;
            end else begin
                count_d = '0;
                wrap_d  = 1'b1;
            end
        end
    end

    assign sat_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;
    assign tc_o    = (count_q == limit_i);

endmodule

// File: tb/tb_e_9_upcount_mod_async.sv
// Bench for e_9_upcount_mod_async (WIDTH=8): directed table, hand sequences, randomized run vs reference model.
module tb_e_9_upcount_mod_async;

    logic       clk;
    logic       rst_n;
    logic       en, clr, load;
    logic [7:0] load_val, limit;
    logic [7:0] count;
    logic       tc, wrap, sat;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_count, m_wrap, m_sat, m_first;

    typedef struct {
        logic       clr, load, en;
        logic [7:0] lv, lim;
        int         cnt, tc, wrap;
    } vec_t;
    vec_t vecs[$];

    e_9_upcount_mod_async #(.WIDTH(8)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .clr_i      (clr),
        .load_i     (load),
        .load_val_i (load_val),
        .limit_i    (limit),
        .count_o    (count),
        .tc_o       (tc),
        .wrap_o     (wrap),
        .sat_o      (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_wrap = 0; m_sat = 0; m_first = 1;
    endtask

    // Applies the counter rules to the inputs present at this clock edge.
    task automatic model_edge();
        int lv, lim;
        lv  = int'(load_val);
        lim = int'(limit);
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_wrap = 0;
        if (clr) begin
            m_count = 0; m_sat = 0; m_first = 1;
        end else if (load) begin
            m_count = (lv < lim) ? lv : lim;
            if (m_count < lim) m_sat = 0;
            m_first = 1;
        end else if (en) begin
            if (m_count < lim) begin
                m_count = m_count + 1;
            end else begin
`ifdef E_9_SATURATE_EN
                m_count = lim;
                m_wrap  = m_first;
                m_first = 0;
                m_sat   = 1;
`else
                m_count = 0;
                m_wrap  = 1;
`endif
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " count"}, int'(count), m_count);
        chk({tag, " tc"},    int'(tc),    int'(m_count == int'(limit)));
        chk({tag, " wrap"},  int'(wrap),  m_wrap);
        chk({tag, " sat"},   int'(sat),   m_sat);
    endtask

    task automatic add(input logic c, input logic l, input logic e, input logic [7:0] lv,
                       input logic [7:0] lim, input int cnt, input int t, input int w);
        vec_t v;
        v.clr = c; v.load = l; v.en = e; v.lv = lv; v.lim = lim;
        v.cnt = cnt; v.tc = t; v.wrap = w;
        vecs.push_back(v);
    endtask

    task automatic set_in(input logic c, input logic l, input logic e,
                          input logic [7:0] lv, input logic [7:0] lim);
        clr = c; load = l; en = e; load_val = lv; limit = lim;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 8'd0, 8'd5);
        model_reset();
        #12;
        chk("reset count", int'(count), 0);
        chk("reset wrap",  int'(wrap),  0);
        chk("reset sat",   int'(sat),   0);
        chk("reset tc limit5", int'(tc), 0);
        limit = 8'd0;
        #1;
        chk("reset tc limit0", int'(tc), 1);
        // held in reset across an edge with en high
        en = 1'b1;
        step();
        chk("reset holds count", int'(count), 0);
        rst_n = 1'b1;
        model_reset();

`ifndef E_9_SATURATE_EN
        // free count to 255, wrap, continue
        set_in(0, 0, 1, 8'd0, 8'd255);
        for (int k = 1; k <= 258; k++) begin
            step();
            chk("free count", int'(count), k % 256);
            chk("free tc",    int'(tc),    int'((k % 256) == 255));
            chk("free wrap",  int'(wrap),  int'(k == 256));
        end

        //   clr load en  lv   lim   cnt tc wrap
        add(1, 0, 0, 8'd0,   8'd4,  0,  0, 0);
        add(0, 0, 1, 8'd0,   8'd4,  1,  0, 0);
        add(0, 0, 1, 8'd0,   8'd4,  2,  0, 0);
        add(0, 0, 1, 8'd0,   8'd4,  3,  0, 0);
        add(0, 0, 1, 8'd0,   8'd4,  4,  1, 0);
        add(0, 0, 1, 8'd0,   8'd4,  0,  0, 1);
        add(0, 0, 1, 8'd0,   8'd4,  1,  0, 0);
        add(0, 1, 0, 8'd3,   8'd4,  3,  0, 0);
        add(1, 1, 1, 8'd7,   8'd4,  0,  0, 0);
        add(0, 1, 0, 8'd200, 8'd10, 10, 1, 0);
        add(0, 0, 1, 8'd0,   8'd10, 0,  0, 1);
        add(0, 1, 0, 8'd9,   8'd10, 9,  0, 0);
        add(0, 0, 1, 8'd0,   8'd4,  0,  0, 1);
        add(0, 0, 1, 8'd0,   8'd0,  0,  1, 1);
        add(0, 0, 1, 8'd0,   8'd0,  0,  1, 1);
        add(0, 0, 0, 8'd0,   8'd0,  0,  1, 0);
        add(0, 1, 0, 8'd5,   8'd7,  5,  0, 0);
        add(0, 0, 1, 8'd0,   8'd7,  6,  0, 0);
        add(0, 0, 1, 8'd0,   8'd7,  7,  1, 0);
        add(0, 1, 1, 8'd2,   8'd7,  2,  0, 0);
        add(0, 0, 0, 8'd0,   8'd7,  2,  0, 0);
        foreach (vecs[i]) begin
            set_in(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].lv, vecs[i].lim);
            step();
            chk($sformatf("vec%0d count", i), int'(count), vecs[i].cnt);
            chk($sformatf("vec%0d tc", i),    int'(tc),    vecs[i].tc);
            chk($sformatf("vec%0d wrap", i),  int'(wrap),  vecs[i].wrap);
        end
`else
        // saturate build: limit=3, six enabled edges
        set_in(1, 0, 0, 8'd0, 8'd3);
        step();
        set_in(0, 0, 1, 8'd0, 8'd3);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("sat seq count", int'(count), (k < 3) ? k : 3);
            chk("sat seq sat",   int'(sat),   int'(k >= 4));
            chk("sat seq wrap",  int'(wrap),  int'(k == 4));
        end
        set_in(1, 0, 0, 8'd0, 8'd3);
        step();
        chk("sat clr count", int'(count), 0);
        chk("sat clr sat",   int'(sat),   0);
        set_in(0, 1, 0, 8'd9, 8'd4);
        step();
        set_in(0, 0, 1, 8'd0, 8'd4);
        step();
        chk("sat lowered count", int'(count), 4);
        chk("sat lowered sat",   int'(sat),   1);
`endif

        // async reset between edges at count 7
        set_in(1, 0, 0, 8'd0, 8'd20);
        step();
        set_in(0, 0, 1, 8'd0, 8'd20);
        for (int k = 0; k < 7; k++) step();
        chk("pre-reset count", int'(count), 7);
        #3 rst_n = 1'b0;
        #1;
        chk("async reset count", int'(count), 0);
        chk("async reset wrap",  int'(wrap),  0);
        model_reset();
        #1 rst_n = 1'b1;

        // async reset during a wrap pulse
        set_in(0, 0, 1, 8'd0, 8'd0);
        step();
        chk("pulse before reset", int'(wrap), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset during wrap", int'(wrap), 0);
        model_reset();
        #1 rst_n = 1'b1;

        // randomized run against the model
        set_in(0, 0, 0, 8'd0, 8'd6);
        for (int k = 0; k < 2000; k++) begin
            clr      = ($urandom_range(0, 15) == 0);
            load     = ($urandom_range(0, 7) == 0);
            en       = ($urandom_range(0, 3) != 0);
            load_val = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0)
                limit = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                    : 8'($urandom_range(0, 12));
            step();
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
